// File: rtl/compound_initiator_pkg.sv
// Shared types for the CompoundType blocking-port handshake.
//   top_level_types          : CompoundType payload and its mode enum, shared
//                              with the responder side.
//   compound_initiator_types : initiator FSM sections, req_out reset value and
//                              the message generator helper.
package top_level_types;

  typedef enum logic {
    read  = 1'b0,
    write = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e       mode;
    logic [31:0] x;
    logic        y;
  } CompoundType;

endpackage

package compound_initiator_types;
  import top_level_types::*;

  typedef enum logic [1:0] {
    section_idle,
    section_run,
    section_drain
  } Sections;

  localparam CompoundType REQ_OUT_RST = '{mode: read, x: 32'd0, y: 1'b0};

  // Message k: even k writes, odd k reads, y mirrors bit 1 of k.
  // Only the two low bits of k matter, so the caller passes those alone.
  function automatic CompoundType msg_at(input logic [1:0] k_lo, input logic [31:0] x);
    CompoundType m;
    m.mode = k_lo[0] ? read : write;
    m.x    = x;
    m.y    = k_lo[1];
    return m;
  endfunction

endpackage

// File: rtl/compound_initiator_if.sv
// Handshake bundle between compound_initiator and its responder.
//   req_out / req_out_notify / req_out_sync : request channel (initiator -> peer)
//   rsp_in  / rsp_in_sync   / rsp_in_notify : response channel (peer -> initiator)
// A transfer happens on a rising edge where notify and sync are both high.
// Modports: master = initiator side, slave = responder side.
interface compound_initiator_if;
  import top_level_types::*;

  CompoundType req_out;
  logic        req_out_sync;
  logic        req_out_notify;
  CompoundType rsp_in;
  logic        rsp_in_sync;
  logic        rsp_in_notify;

  modport master (
    output req_out, req_out_notify, rsp_in_notify,
    input  req_out_sync, rsp_in, rsp_in_sync
  );

  modport slave (
    input  req_out, req_out_notify, rsp_in_notify,
    output req_out_sync, rsp_in, rsp_in_sync
  );

endinterface

// File: rtl/compound_fifo.sv
// Expected-response FIFO for compound_initiator.
// Ports: clk, rst (async, active-high), push/din, pop/dout (head, valid when
// not empty), count, full, empty. Simultaneous push and pop keeps count.
// DEPTH must be a power of two so the pointers wrap naturally.
// STORE=0 keeps only occupancy; dout then reads as zero.
module compound_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1,
  parameter bit STORE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

  generate
    if (STORE) begin : g_mem
      logic [W-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
      end
      assign dout = mem[rp];
    end else begin : g_nomem
      logic unused_din;
      assign unused_din = ^din;
      assign dout = '0;
    end
  endgenerate

endmodule

// File: rtl/compound_initiator.sv
// Request-side peer for the CompoundType blocking-port handshake.
// Generates messages 0..N-1 on bus.req_out and consumes the matching
// responses on bus.rsp_in with up to DEPTH requests outstanding.
// Ports: clk, rst (async, active-high), start/num_msgs/x_seed (run request),
//        bus (compound_initiator_if.master), busy, done (1-cycle pulse),
//        err_count (saturating response mismatches of the last run).
// Build option: COMPOUND_INITIATOR_CHECK_EN enables field-by-field response
// checking; without it the FIFO tracks occupancy only and err_count is 0.
module compound_initiator
  import top_level_types::*;
  import compound_initiator_types::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_msgs,
  input  logic [31:0]          x_seed,
  compound_initiator_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     err_count
);
  localparam int PW = $bits(CompoundType);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  Sections          state, state_nxt;
  logic             done_nxt, run_start;
  logic [CNT_W-1:0] n_msgs, sent, rcvd, sent_inc;
  CompoundType      req_q;
  logic             req_xfer, rsp_xfer, req_vld, rsp_rdy;
  logic             fifo_full, fifo_empty;
  logic [PW-1:0]    fifo_head;
  logic [$clog2(DEPTH):0] unused_fifo_count;

`ifdef COMPOUND_INITIATOR_CHECK_EN
  localparam bit STORE = 1'b1;
`else
  localparam bit STORE = 1'b0;
`endif

  // Notifies are pure functions of registered state, so they only move on edges.
  assign req_vld  = (state == section_run) && (sent < n_msgs) && !fifo_full;
  assign rsp_rdy  = !fifo_empty;
  assign req_xfer = req_vld && bus.req_out_sync;
  assign rsp_xfer = rsp_rdy && bus.rsp_in_sync;
  assign sent_inc = sent + ONE;

  assign bus.req_out        = req_q;
  assign bus.req_out_notify = req_vld;
  assign bus.rsp_in_notify  = rsp_rdy;
  assign busy               = (state != section_idle);

  compound_fifo #(.DEPTH(DEPTH), .W(PW), .STORE(STORE)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_xfer),
    .din   (req_q),
    .pop   (rsp_xfer),
    .dout  (fifo_head),
    .count (unused_fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= section_idle;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    run_start = 1'b0;
    case (state)
      section_idle: begin
        if (start) begin
          if (num_msgs == '0) begin
            done_nxt = 1'b1;
          end else begin
            run_start = 1'b1;
            state_nxt = section_run;
          end
        end
      end
      section_run: begin
        if (req_xfer && (sent_inc == n_msgs)) state_nxt = section_drain;
      end
      section_drain: begin
        // The last push always precedes the last pop, so completion is only
        // ever observed here.
        if (rsp_xfer && ((rcvd + ONE) == n_msgs)) begin
          done_nxt  = 1'b1;
          state_nxt = section_idle;
        end
      end
      default: state_nxt = section_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_msgs <= '0;
      sent   <= '0;
      rcvd   <= '0;
      req_q  <= REQ_OUT_RST;
      done   <= 1'b0;
    end else begin
      done <= done_nxt;
      if (run_start) begin
        n_msgs <= num_msgs;
        sent   <= '0;
        rcvd   <= '0;
        req_q  <= msg_at(2'b00, x_seed);
      end else begin
        // After the last push the register holds message N, which is never
        // offered because sent == N drops notify.
        if (req_xfer) begin
          sent  <= sent_inc;
          req_q <= msg_at(sent_inc[1:0], req_q.x + 32'd1);
        end
        if (rsp_xfer) rcvd <= rcvd + ONE;
      end
    end
  end

`ifdef COMPOUND_INITIATOR_CHECK_EN
  logic [CNT_W-1:0] err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (run_start) begin
      err_q <= '0;
    end else if (rsp_xfer && (bus.rsp_in != CompoundType'(fifo_head)) && (err_q != '1)) begin
      err_q <= err_q + ONE;
    end
  end
  assign err_count = err_q;
`else
  logic unused_chk;
  assign unused_chk = ^{bus.rsp_in, fifo_head};
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_compound_initiator.sv
module tb_compound_initiator;
  import top_level_types::*;
  import compound_initiator_types::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
`ifdef COMPOUND_INITIATOR_CHECK_EN
  localparam logic [CNT_W-1:0] EXP_ERR1 = 16'd1;
`else
  localparam logic [CNT_W-1:0] EXP_ERR1 = 16'd0;
`endif

  logic             clk, rst, start, busy, done;
  logic [CNT_W-1:0] num_msgs, err_count;
  logic [31:0]      x_seed;

  compound_initiator_if ifc();

  compound_initiator #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_msgs  (num_msgs),
    .x_seed    (x_seed),
    .bus       (ifc.master),
    .busy      (busy),
    .done      (done),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // echo responder state + observation logs
  CompoundType rq[$];
  int          rt[$];
  CompoundType req_log[$];
  int          req_cyc[$];
  int          rsp_cnt;
  bit          rsp_hold = 1'b0;
  bit          req_sync_en = 1'b1;
  int          corrupt_idx = -1;
  logic [31:0] corrupt_x = 32'd0;

  // One clock cycle, entered and left at a negedge. Inputs are driven here,
  // and transfers at the coming posedge are predicted from stable values.
  task automatic tick();
    CompoundType p;
    int idx;
    if (!rsp_hold && rq.size() > 0 && rt[0] <= cyc) begin
      ifc.rsp_in      = rq[0];
      ifc.rsp_in_sync = 1'b1;
    end else begin
      ifc.rsp_in      = '0;
      ifc.rsp_in_sync = 1'b0;
    end
    ifc.req_out_sync = req_sync_en;
    #1;
    if (ifc.rsp_in_notify && ifc.rsp_in_sync) begin
      void'(rq.pop_front());
      void'(rt.pop_front());
      rsp_cnt++;
    end
    if (ifc.req_out_notify && ifc.req_out_sync) begin
      p   = ifc.req_out;
      idx = req_log.size();
      req_log.push_back(p);
      req_cyc.push_back(cyc);
      if (idx == corrupt_idx) p.x = corrupt_x;
      rq.push_back(p);
      rt.push_back(cyc + 2);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic kick(input logic [CNT_W-1:0] n, input logic [31:0] seed);
    req_log.delete();
    req_cyc.delete();
    rsp_cnt  = 0;
    start    = 1'b1;
    num_msgs = n;
    x_seed   = seed;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    seen = (done === 1'b1);
  endtask

  task automatic test_reset();
    bit bad = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ifc.req_out !== REQ_OUT_RST) begin errors++; $display("FAIL rst_req_out: got %h want %h", ifc.req_out, REQ_OUT_RST); end
    checks++; if (ifc.req_out_notify !== 1'b0) begin errors++; $display("FAIL rst_req_notify: got %b want 0", ifc.req_out_notify); end
    checks++; if (ifc.rsp_in_notify !== 1'b0) begin errors++; $display("FAIL rst_rsp_notify: got %b want 0", ifc.rsp_in_notify); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rst_busy_done: got %b want 00", {busy, done}); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rst_err: got %0d want 0", err_count); end
    rst = 1'b0;
    repeat (10) begin
      tick();
      if (busy !== 1'b0 || ifc.req_out_notify !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL idle_quiet: got busy/notify activity want none"); end
  endtask

  task automatic test_basic();
    bit seen;
    int c0;
    c0 = cyc;
    kick(3, 32'd10);
    checks++; if ({busy, ifc.req_out_notify} !== 2'b11) begin errors++; $display("FAIL basic_start: got busy,notify=%b want 11", {busy, ifc.req_out_notify}); end
    wait_done(seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL basic_done: got no done want pulse"); end
    checks++; if (req_log.size() !== 3) begin errors++; $display("FAIL basic_nreq: got %0d want 3", req_log.size()); end
    if (req_log.size() == 3) begin
      checks++; if (req_log[0] !== CompoundType'{mode: write, x: 32'd10, y: 1'b0}) begin errors++; $display("FAIL basic_msg0: got %h", req_log[0]); end
      checks++; if (req_log[1] !== CompoundType'{mode: read, x: 32'd11, y: 1'b0}) begin errors++; $display("FAIL basic_msg1: got %h", req_log[1]); end
      checks++; if (req_log[2] !== CompoundType'{mode: write, x: 32'd12, y: 1'b1}) begin errors++; $display("FAIL basic_msg2: got %h", req_log[2]); end
      checks++; if (req_cyc[0] !== c0 + 1 || req_cyc[2] !== c0 + 3) begin errors++; $display("FAIL basic_timing: got cycles %0d,%0d want %0d,%0d", req_cyc[0], req_cyc[2], c0 + 1, c0 + 3); end
    end
    checks++; if (rsp_cnt !== 3 || busy !== 1'b0) begin errors++; $display("FAIL basic_rsp: got rsp=%0d busy=%b want 3,0", rsp_cnt, busy); end
    checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL basic_err: got %0d want 0", err_count); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_pulse: got done=%b want 0", done); end
  endtask

  task automatic test_backpressure();
    bit seen;
    rsp_hold = 1'b1;
    kick(6, 32'd100);
    repeat (10) tick();
    checks++; if (req_log.size() !== 4 || ifc.req_out_notify !== 1'b0) begin errors++; $display("FAIL bp_full: got nreq=%0d notify=%b want 4,0", req_log.size(), ifc.req_out_notify); end
    checks++; if (ifc.rsp_in_notify !== 1'b1) begin errors++; $display("FAIL bp_rsp_notify: got %b want 1", ifc.rsp_in_notify); end
    rsp_hold = 1'b0;
    wait_done(seen);
    checks++; if (seen !== 1'b1 || req_log.size() !== 6 || rsp_cnt !== 6) begin errors++; $display("FAIL bp_done: got done=%b nreq=%0d rsp=%0d want 1,6,6", seen, req_log.size(), rsp_cnt); end
    if (req_log.size() == 6) begin
      checks++; if (req_log[5] !== CompoundType'{mode: read, x: 32'd105, y: 1'b0}) begin errors++; $display("FAIL bp_msg5: got %h", req_log[5]); end
      checks++; if (req_log[3] !== CompoundType'{mode: read, x: 32'd103, y: 1'b1}) begin errors++; $display("FAIL bp_msg3: got %h", req_log[3]); end
    end
  endtask

  task automatic test_mismatch();
    bit seen;
    corrupt_idx = 1;
    corrupt_x   = 32'd12;
    kick(3, 32'd10);
    wait_done(seen);
    corrupt_idx = -1;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mm_done: got no done want pulse"); end
    checks++; if (err_count !== EXP_ERR1) begin errors++; $display("FAIL mm_err: got %0d want %0d", err_count, EXP_ERR1); end
    tick();
    checks++; if (err_count !== EXP_ERR1) begin errors++; $display("FAIL mm_err_hold: got %0d want %0d", err_count, EXP_ERR1); end
  endtask

  task automatic test_zero_and_wrap();
    bit seen;
    bit bad = 1'b0;
    kick(0, 32'd5);
    checks++; if ({done, busy, ifc.req_out_notify} !== 3'b100) begin errors++; $display("FAIL zero_done: got done,busy,notify=%b want 100", {done, busy, ifc.req_out_notify}); end
    repeat (5) begin
      tick();
      if (busy !== 1'b0 || ifc.req_out_notify !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL zero_quiet: got activity after empty run want none"); end
    kick(2, 32'hFFFF_FFFF);
    wait_done(seen);
    checks++; if (seen !== 1'b1 || req_log.size() !== 2) begin errors++; $display("FAIL wrap_done: got done=%b nreq=%0d want 1,2", seen, req_log.size()); end
    if (req_log.size() == 2) begin
      checks++; if (req_log[0].x !== 32'hFFFF_FFFF || req_log[1].x !== 32'h0) begin errors++; $display("FAIL wrap_x: got %h,%h want ffffffff,00000000", req_log[0].x, req_log[1].x); end
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    kick(1, 32'd0);
    wait_done(seen);
    kick(2, 32'd20);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    wait_done(seen);
    checks++; if (seen !== 1'b1 || req_log.size() !== 2) begin errors++; $display("FAIL b2b_done: got done=%b nreq=%0d want 1,2", seen, req_log.size()); end
    if (req_log.size() == 2) begin
      checks++; if (req_log[1] !== CompoundType'{mode: read, x: 32'd21, y: 1'b0}) begin errors++; $display("FAIL b2b_msg1: got %h", req_log[1]); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int n = 0;
    rsp_hold = 1'b1;
    kick(5, 32'd50);
    while (req_log.size() < 2 && n < 20) begin tick(); n++; end
    checks++; if (req_log.size() !== 2) begin errors++; $display("FAIL mid_setup: got nreq=%0d want 2", req_log.size()); end
    rst = 1'b1;
    #1;
    checks++; if ({busy, ifc.req_out_notify, ifc.rsp_in_notify} !== 3'b000) begin errors++; $display("FAIL mid_rst: got busy,rq,rs=%b want 000", {busy, ifc.req_out_notify, ifc.rsp_in_notify}); end
    checks++; if (ifc.req_out !== REQ_OUT_RST) begin errors++; $display("FAIL mid_rst_req: got %h want %h", ifc.req_out, REQ_OUT_RST); end
    rq.delete();
    rt.delete();
    rsp_hold = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (ifc.rsp_in_notify !== 1'b0) begin errors++; $display("FAIL mid_fifo_empty: got rsp_notify=%b want 0", ifc.rsp_in_notify); end
    kick(1, 32'd7);
    wait_done(seen);
    checks++; if (seen !== 1'b1 || err_count !== 16'd0) begin errors++; $display("FAIL mid_rerun: got done=%b err=%0d want 1,0", seen, err_count); end
    if (req_log.size() == 1) begin
      checks++; if (req_log[0] !== CompoundType'{mode: write, x: 32'd7, y: 1'b0}) begin errors++; $display("FAIL mid_msg0: got %h", req_log[0]); end
    end else begin
      checks++; errors++; $display("FAIL mid_nreq: got %0d want 1", req_log.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_msgs = '0;
    x_seed = '0;
    ifc.req_out_sync = 1'b0;
    ifc.rsp_in_sync = 1'b0;
    ifc.rsp_in = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_mismatch();
    test_zero_and_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
